// File: rtl/bitwise_pkg.sv
// Shared op-code constants and types for the bitwise pipeline.
package bitwise_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/bitwise_core.sv
// Purely combinational bitwise operator: y = op(a, b) over WIDTH bits.
module bitwise_core
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/bitwise_pipe.sv
// Two-stage valid/ready bitwise pipeline with a result accumulator that can
// stand in for operand B.
module bitwise_pipe
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_t              s1_op;
    logic             s1_use_acc;

    logic             s2_valid;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             neg_q;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_y;
    logic             s1_advance;
    logic             in_fire;

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign s1_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign core_b     = s1_use_acc ? acc : s1_b;

    bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (s1_a),
        .b  (core_b),
        .op (s1_op),
        .y  (core_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_AND;
            s1_use_acc <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_a       <= a;
            s1_b       <= b;
            s1_op      <= op;
            s1_use_acc <= use_acc;
        end else if (s1_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    // S2 only reloads when it is empty or draining, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= 1'b1;
            out_q    <= core_y;
            zero_q   <= (core_y == '0);
            neg_q    <= core_y[WIDTH-1];
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Clear wins over the load; the advancing op has already seen the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s1_advance) begin
            acc <= core_y;
        end
    end

    assign out_valid = s2_valid;
    assign out       = out_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Randomized and directed bench for bitwise_pipe, checked against a
// truth-table reference model with an in-order expected-result queue.
module tb_bitwise_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         use_acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         neg;

    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           n_received   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         got_zero_q[$];
    logic         got_neg_q[$];
    logic [W-1:0] model_acc = '0;
    logic [3:0]   truth_tab[8];

    int           base;
    int           idx;
    logic         took;
    logic [W-1:0] v;
    logic [W-1:0] bp_a[3];

    always #5 clk = ~clk;

    bitwise_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .use_acc   (use_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .neg       (neg)
    );

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] sel);
        logic [3:0]   tt;
        logic [W-1:0] r;
        tt = truth_tab[sel];
        r  = '0;
        for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitorCycle();
        logic [W-1:0] r;
        if (!rst_n) begin
            exp_q.delete();
            model_acc = '0;
            return;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                checkOutput("out", 64'(out), 64'(exp_q[0]));
                checkOutput("zero", 64'(zero), 64'(exp_q[0] == '0));
                checkOutput("neg", 64'(neg), 64'(exp_q[0][W-1]));
                if (out_ready) begin
                    got_q.push_back(out);
                    got_zero_q.push_back(zero);
                    got_neg_q.push_back(neg);
                    void'(exp_q.pop_front());
                    n_received++;
                end
            end
        end
        if (acc_clr) model_acc = '0;
        if (in_valid && in_ready) begin
            r = ref_op(a, use_acc ? model_acc : b, op);
            model_acc = r;
            exp_q.push_back(r);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic [2:0] vop, input logic vuse);
        logic ok;
        a        = va;
        b        = vb;
        op       = vop;
        use_acc  = vuse;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            ok = in_ready;
            stepCycle();
            if (ok) return;
        end
        checkOutput("accept_timeout", 64'(1), 64'(0));
    endtask

    task automatic drainPipe();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0 && !out_valid) return;
            stepCycle();
        end
        checkOutput("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        truth_tab[0] = 4'b1000;
        truth_tab[1] = 4'b1110;
        truth_tab[2] = 4'b0110;
        truth_tab[3] = 4'b0111;
        truth_tab[4] = 4'b0001;
        truth_tab[5] = 4'b1001;
        truth_tab[6] = 4'b0011;
        truth_tab[7] = 4'b1100;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        use_acc   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        stepCycle();
        stepCycle();
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out", 64'(out), 64'(0));
        checkOutput("reset_zero", 64'(zero), 64'(0));
        checkOutput("reset_neg", 64'(neg), 64'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));

        // Directed AND with latency check.
        out_ready = 1'b1;
        applyStimulus(16'h0371, 16'hCEE0, 3'd0, 1'b0);
        in_valid = 1'b0;
        checkOutput("lat_first_cycle_valid", 64'(out_valid), 64'(0));
        stepCycle();
        checkOutput("lat_second_cycle_valid", 64'(out_valid), 64'(1));
        checkOutput("and_out", 64'(out), 64'(16'h0260));
        checkOutput("and_zero", 64'(zero), 64'(0));
        checkOutput("and_neg", 64'(neg), 64'(0));
        drainPipe();

        // Back-to-back throughput.
        base = n_received;
        for (int i = 0; i < 30; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            op       = 3'd0;
            use_acc  = 1'b0;
            in_valid = 1'b1;
            #1;
            checkOutput("tput_in_ready", 64'(in_ready), 64'(1));
            stepCycle();
        end
        in_valid = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("tput_count", 64'(n_received - base), 64'(30));
        drainPipe();

        // Backpressure: two accepted, then stall, then release.
        for (int i = 0; i < 3; i++) bp_a[i] = W'($urandom);
        out_ready = 1'b0;
        idx       = 0;
        base      = n_received;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 3);
            a        = bp_a[idx % 3];
            b        = 16'h5A3C;
            op       = 3'(idx + 1);
            use_acc  = 1'b0;
            #1;
            if (cyc >= 2) checkOutput("bp_in_ready_low", 64'(in_ready), 64'(0));
            took = in_valid && in_ready;
            stepCycle();
            if (took) idx++;
        end
        checkOutput("bp_accepted", 64'(idx), 64'(2));
        checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
        checkOutput("bp_none_delivered", 64'(n_received - base), 64'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 50 && idx < 3; k++) begin
            in_valid = 1'b1;
            a        = bp_a[idx];
            op       = 3'(idx + 1);
            #1;
            took = in_ready;
            stepCycle();
            if (took) idx++;
        end
        drainPipe();
        checkOutput("bp_count", 64'(n_received - base), 64'(3));

        // Accumulator chain after a clear.
        acc_clr = 1'b1;
        stepCycle();
        acc_clr = 1'b0;
        got_q.delete();
        applyStimulus(16'h00F0, W'($urandom), 3'd1, 1'b1);
        applyStimulus(16'h0FF0, W'($urandom), 3'd2, 1'b1);
        drainPipe();
        checkOutput("acc_chain_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() >= 2) begin
            checkOutput("acc_chain_or", 64'(got_q[0]), 64'(16'h00F0));
            checkOutput("acc_chain_xor", 64'(got_q[1]), 64'(16'h0F00));
        end

        // Clear coinciding with an advance: that op sees the old accumulator.
        got_q.delete();
        applyStimulus(16'h1234, 16'h0000, 3'd7, 1'b0);
        drainPipe();
        applyStimulus(16'h0001, W'($urandom), 3'd1, 1'b1);
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        stepCycle();
        acc_clr  = 1'b0;
        applyStimulus(16'h00FF, W'($urandom), 3'd2, 1'b1);
        drainPipe();
        checkOutput("clr_prio_count", 64'(got_q.size()), 64'(3));
        if (got_q.size() >= 3) begin
            checkOutput("clr_prio_old_acc", 64'(got_q[1]), 64'(16'h1235));
            checkOutput("clr_prio_cleared", 64'(got_q[2]), 64'(16'h00FF));
        end

        // Flag corners.
        got_q.delete();
        got_zero_q.delete();
        got_neg_q.delete();
        applyStimulus(16'hFFFF, 16'h0000, 3'd4, 1'b0);
        applyStimulus(16'h0002, W'($urandom), 3'd6, 1'b0);
        drainPipe();
        checkOutput("flags_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() >= 2) begin
            checkOutput("nor_out", 64'(got_q[0]), 64'(16'h0000));
            checkOutput("nor_zero", 64'(got_zero_q[0]), 64'(1));
            checkOutput("not_out", 64'(got_q[1]), 64'(16'hFFFD));
            checkOutput("not_neg", 64'(got_neg_q[1]), 64'(1));
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            op        = 3'($urandom_range(0, 7));
            use_acc   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        drainPipe();

        // Reset with both stages full.
        out_ready = 1'b0;
        applyStimulus(W'($urandom), W'($urandom), 3'd7, 1'b0);
        applyStimulus(W'($urandom), W'($urandom), 3'd7, 1'b0);
        in_valid = 1'b0;
        stepCycle();
        checkOutput("rst_full_out_valid", 64'(out_valid), 64'(1));
        checkOutput("rst_full_in_ready", 64'(in_ready), 64'(0));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_async_out", 64'(out), 64'(0));
        stepCycle();
        stepCycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_release_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_no_stale", 64'(out_valid), 64'(0));
            stepCycle();
        end
        got_q.delete();
        v = W'($urandom);
        applyStimulus(v, W'($urandom), 3'd7, 1'b0);
        drainPipe();
        checkOutput("rst_first_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() >= 1) checkOutput("rst_first_out", 64'(got_q[0]), 64'(v));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
